feed_forward_layer_scheduler: RTL

Sequencer that time-multiplexes one shared `feed_forward_node` datapath across all nodes of a Q-network layer. On a start request it works through node indices 0..NUMBER_OF_NODES-1. For each index it issues the node address and weight base to the datapath, pulses its valid, waits for the result, and writes the result into the layer output RAM. It sits between the DQN top-level control (layer start/done) and the node datapath plus its output buffer.

---
 rtl/dqn_pkg.sv | 24 ++
 rtl/feed_forward_layer_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN layer datapath blocks.
//   state_t        : layer scheduler state encoding
//   DQN_*          : default widths used by the layer blocks
//   weight_stride  : weight row stride for a node with n_inputs inputs (bias included)
package dqn_pkg;

  localparam int DQN_DATA_WIDTH     = 32;
  localparam int DQN_ADDRESS_WIDTH  = 5;
  localparam int DQN_DEFAULT_INPUTS = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Each weight row holds one weight per input plus the bias term.
  function automatic int weight_stride(input int n_inputs);
    return n_inputs + 1;
  endfunction

endpackage

// File: rtl/feed_forward_layer_scheduler.sv
// Sequences one shared feed_forward_node datapath over every node of a layer.
// For each node index it issues the node address and weight base, pulses the
// datapath valid, waits (bounded by a timeout) for the result and writes the
// result into the layer output RAM.
//
// Ports:
//   clk                 clock, rising edge
//   rst_n               synchronous reset, active-high despite the name
//   i_start             start a layer (accepted only in IDLE)
//   o_busy              high whenever not IDLE
//   o_done              one-cycle pulse at end of layer (normal or aborted)
//   o_error             sticky timeout flag, cleared by reset or accepted start
//   o_node_valid        one-cycle start pulse to the datapath
//   o_node_addr         current node index
//   o_node_weight_base  index * stride, truncated
//   i_node_data         datapath result
//   i_node_valid        datapath result valid
//   o_wr_en/addr/data   output RAM write port
module feed_forward_layer_scheduler
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH           = DQN_DATA_WIDTH,
  parameter int ADDRESS_WIDTH        = DQN_ADDRESS_WIDTH,
  parameter int NUMBER_OF_NODES      = 8,
  parameter int NUMBER_OF_INPUT_NODE = DQN_DEFAULT_INPUTS,
  parameter int WEIGHT_ADDR_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic                         o_node_valid,
  output logic [ADDRESS_WIDTH-1:0]     o_node_addr,
  output logic [WEIGHT_ADDR_WIDTH-1:0] o_node_weight_base,
  input  logic [DATA_WIDTH-1:0]        i_node_data,
  input  logic                         i_node_valid,
  output logic                         o_wr_en,
  output logic [ADDRESS_WIDTH-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0]        o_wr_data
);

  localparam logic [ADDRESS_WIDTH-1:0]     LAST_IDX = ADDRESS_WIDTH'(NUMBER_OF_NODES - 1);
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] STRIDE_W =
    WEIGHT_ADDR_WIDTH'(weight_stride(NUMBER_OF_INPUT_NODE));
  localparam logic [7:0]                   TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                         state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]       idx_q, idx_d;
  logic [WEIGHT_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]          data_q, data_d;
  logic                           err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          base_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // A result arriving on the final allowed cycle still wins over the abort.
        if (i_node_valid) begin
          data_d  = i_node_data;
          state_d = ST_WRITE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          // Running accumulator keeps the weight base free of a multiplier.
          idx_d   = idx_q + 1'b1;
          base_d  = base_q + STRIDE_W;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output comes from a flop.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_node_valid <= 1'b0;
      o_wr_en      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
      o_busy       <= (state_d != ST_IDLE);
      o_done       <= (state_d == ST_DONE);
      o_node_valid <= (state_d == ST_ISSUE);
      o_wr_en      <= (state_d == ST_WRITE);
    end
  end

  assign o_error            = err_q;
  assign o_node_addr        = idx_q;
  assign o_node_weight_base = base_q;
  assign o_wr_addr          = idx_q;
  assign o_wr_data          = data_q;

endmodule
